// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter:
// register address width, register count, the r0 constant and the
// writeback source encoding.
package rf_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Outstanding-load scoreboard: one pending bit per architectural register.
// A dispatched load sets its destination bit and the returning load data
// clears it. When both hit the same register in one cycle the set wins,
// because a newer load to that register is now outstanding. r0 is never
// tracked.
module rf_scoreboard
    import rf_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] chk_addr_1,
    input  logic [REG_ADDR_W-1:0] chk_addr_2,
    input  logic [REG_ADDR_W-1:0] waw_addr,
    output logic                  hazard,
    output logic                  waw_hit
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;

    // Next pending vector: apply the clear first so a same-address set overrides it.
    always_comb begin
        pending_nxt = pending;
        if (clr_en)
            pending_nxt[clr_addr] = 1'b0;
        if (set_en && (set_addr != REG_ZERO))
            pending_nxt[set_addr] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    // Pending bit register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

    // Lookups are from registered state only; a same-cycle set is not visible.
    assign hazard  = pending[chk_addr_1] | pending[chk_addr_2];
    assign waw_hit = pending[waw_addr];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter. Shares the single Regfile write port
// between ALU results and (possibly late) load data. Loads win by default;
// an ALU result to a register with an outstanding load is held back so the
// late load cannot clobber the younger ALU value.
// Optional: define RF_WB_STARVE_GUARD_EN to let a blocked ALU result win
// one cycle after MAX_WAIT consecutive losses to load data.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int bit_size = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_addr,
    input  logic [bit_size-1:0]   alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_addr,
    input  logic [bit_size-1:0]   mem_data,
    output logic                  mem_ready,
    input  logic                  pend_set,
    input  logic [REG_ADDR_W-1:0] pend_addr,
    input  logic [REG_ADDR_W-1:0] chk_addr_1,
    input  logic [REG_ADDR_W-1:0] chk_addr_2,
    output logic                  hazard,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] Write_addr,
    output logic [bit_size-1:0]   Write_data
);

    if (bit_size < 1 || MAX_WAIT < 0) begin : g_param_check
        $error("rf_wb_arbiter: bad parameters");
    end

    logic waw_hit;
    src_e grant_src;
    logic grant;

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (pend_set),
        .set_addr  (pend_addr),
        .clr_en    (mem_ready),
        .clr_addr  (mem_addr),
        .chk_addr_1(chk_addr_1),
        .chk_addr_2(chk_addr_2),
        .waw_addr  (alu_addr),
        .hazard    (hazard),
        .waw_hit   (waw_hit)
    );

`ifdef RF_WB_STARVE_GUARD_EN
    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             alu_force;

    // ALU takes the port for one cycle once it has lost MAX_WAIT times in a row.
    assign alu_force = alu_valid & ~waw_hit & (wait_cnt == CNT_W'(MAX_WAIT));

    // Grant: mem first unless the starvation guard has fired.
    always_comb begin
        mem_ready = mem_valid & ~alu_force;
        alu_ready = alu_valid & ~waw_hit & (~mem_valid | alu_force);
    end

    // Count only losses to mem priority; WAW stalls are not starvation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (alu_ready)
            wait_cnt <= '0;
        else if (alu_valid && !waw_hit && mem_valid && (wait_cnt != CNT_W'(MAX_WAIT)))
            wait_cnt <= wait_cnt + 1'b1;
    end
`else
    // Grant: strict mem priority, ALU also held back by a WAW hazard.
    always_comb begin
        mem_ready = mem_valid;
        alu_ready = alu_valid & ~waw_hit & ~mem_valid;
    end
`endif

    assign grant     = alu_ready | mem_ready;
    assign grant_src = mem_ready ? SRC_MEM : SRC_ALU;

    // Write port register; address/data hold when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWrite   <= 1'b0;
            Write_addr <= '0;
            Write_data <= '0;
        end else begin
            RegWrite <= grant;
            if (grant) begin
                Write_addr <= (grant_src == SRC_MEM) ? mem_addr : alu_addr;
                Write_data <= (grant_src == SRC_MEM) ? mem_data : alu_data;
            end
        end
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: ALU results and load data returning from the data cache.
- Load data can arrive many cycles late on a cache miss. A 32-entry scoreboard tracks destination registers with outstanding loads and raises a hazard for the issue stage.
- Sits between the EX/MEM writeback paths and the Regfile write port; drives RegWrite, Write_addr and Write_data.

Parameters:
- bit_size, 32, data width of the register file.
- MAX_WAIT, 4, consecutive blocked ALU cycles before the starvation guard fires (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- alu_valid  input  1  ALU result present.
- alu_addr  input  5  ALU destination register.
- alu_data  input  bit_size  ALU result.
- alu_ready  output  1  ALU result accepted this cycle.
- mem_valid  input  1  load data present.
- mem_addr  input  5  load destination register.
- mem_data  input  bit_size  load data.
- mem_ready  output  1  load data accepted this cycle.
- pend_set  input  1  issue stage dispatched a load.
- pend_addr  input  5  destination register of the dispatched load.
- chk_addr_1  input  5  issue-stage source register 1.
- chk_addr_2  input  5  issue-stage source register 2.
- hazard  output  1  a checked source register has an outstanding load.
- RegWrite  output  1  registered write enable to the Regfile.
- Write_addr  output  5  registered write address.
- Write_data  output  bit_size  registered write data.

Behaviour:
- Reset (asynchronous): RegWrite=0, Write_addr=0, Write_data=0, pending[31:0]=0, wait_cnt=0. The combinational outputs follow from this state.
- Arbitration (combinational, no FSM beyond wait_cnt):
  - Default priority is mem over ALU.
  - mem_ready = mem_valid.
  - alu_ready = alu_valid & ~mem_valid.
  - A source holds valid/addr/data stable until its ready is seen.
- Write register: on each clk edge, RegWrite <= (alu_ready | mem_ready). Write_addr and Write_data load from the granted source; they hold their previous values when nothing is granted.
- Latency: a source accepted at edge N drives RegWrite high in cycle N+1. The Regfile commits the value at edge N+1.
- Address 0:
  - Writes to r0 are forwarded unchanged; the Regfile drops them.
  - Scoreboard bit 0 is never set.
- Scoreboard:
  - pending[pend_addr] sets when pend_set=1 and pend_addr!=0.
  - pending[mem_addr] clears when mem_ready=1.
  - If set and clear hit the same address in one cycle, set wins (a new load is outstanding).
  - Set and clear on different addresses both take effect.
- hazard = pending[chk_addr_1] | pending[chk_addr_2]. It is combinational from registered state and does not see same-cycle pend_set.
- Write-after-write: if alu_valid targets a register whose pending bit is set, alu_ready is forced to 0 until that bit clears. This stops a late load from overwriting a younger ALU result.
- Reset mid-operation clears all pending bits. Any in-flight write in the RegWrite register is discarded.

Optional Feature:
- Macro: RF_WB_STARVE_GUARD_EN.
- With the macro defined:
  - wait_cnt increments each cycle alu_valid=1 and alu_ready=0 because of mem priority. The WAW block does not count.
  - wait_cnt resets to 0 on an ALU grant.
  - When wait_cnt==MAX_WAIT, the ALU wins for one cycle: mem_ready=0 that cycle and mem is held.
- Without the macro: strict mem priority, and wait_cnt is not instantiated.

Decomposition:
- Shared package: REG_ADDR_W=5, NUM_REGS=32, the r0 constant, and the source-ID encoding (SRC_ALU=0, SRC_MEM=1).
- One natural sub-module: rf_scoreboard. It holds the pending bit vector with set/clear/check ports and the set-wins rule.
- Arbitration and the write register stay in the top level.

Test Plan:
- Reset then idle -> RegWrite=0, hazard=0 for 10 cycles, Write_addr=0.
- ALU only: alu_valid, addr=5, data=0x1234 -> alu_ready same cycle; next cycle RegWrite=1, Write_addr=5, Write_data=0x1234.
- Conflict: alu(addr 3) and mem(addr 7) both valid -> mem_ready=1, alu_ready=0; write of r7 in cycle N+1, then r3 in cycle N+2.
- Scoreboard:
  - pend_set addr=9, then chk_addr_1=9 -> hazard=1.
  - mem return to r9 -> hazard=0 the cycle after the grant.
  - pend_set and mem return to r9 in the same cycle -> bit stays set.
- WAW: pending r4 and alu_valid addr=4 -> alu_ready=0 until mem writes r4; then the ALU write occurs one cycle later.
- Guard (macro on, MAX_WAIT=4): mem_valid held high with alu_valid -> ALU granted on cycle 5. Without the macro -> never granted while mem_valid=1.
